// File: rtl/prog_counter.sv
// Program counter stage feeding instruction fetch and the branch-target lookup.
// Each RUN cycle the PC restarts, halts, holds on a stall, loads a branch target,
// or increments. It also owns IDLE/RUN/DONE run control and a saturating cycle counter.
//
// Ports:
//   Clk       - system clock, rising-edge active
//   Reset     - asynchronous active-low reset
//   Start     - synchronous (re)start request, highest priority
//   StartAddr - entry address loaded on Start
//   Branch    - branch taken this cycle
//   Target    - absolute branch target, sampled only when Branch=1
//   Stall     - hold the PC this cycle; a concurrent Branch is dropped
//   Halt      - current instruction is halt
//   ProgCtr   - current instruction address
//   Busy      - registered, 1 while in RUN
//   Done      - registered, 1 while in DONE
//   Overflow  - sticky PC wrap flag for the current run
//   CycleCnt  - cycles spent in RUN since the last Start, saturating
module prog_counter #(
  parameter int unsigned D = 10,
  parameter int unsigned C = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [D-1:0] StartAddr,
  input  logic         Branch,
  input  logic [D-1:0] Target,
  input  logic         Stall,
  input  logic         Halt,
  output logic [D-1:0] ProgCtr,
  output logic         Busy,
  output logic         Done,
  output logic         Overflow,
  output logic [C-1:0] CycleCnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         ovf_q, ovf_d;
  logic [C-1:0] cnt_q, cnt_d;
  logic         busy_q, done_q;

  // Extra bit catches the wrap from 2^D-1 to 0.
  logic [D:0]   pc_sum;

  assign pc_sum = {1'b0, pc_q} + {{D{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (Start) begin
      state_d = StRun;
      pc_d    = StartAddr;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          // Counts every RUN cycle, including stall and halt cycles.
          if (cnt_q != {C{1'b1}}) begin
            cnt_d = cnt_q + {{(C-1){1'b0}}, 1'b1};
          end
          if (Halt) begin
            state_d = StDone;
          end else if (Stall) begin
            pc_d = pc_q;
          end else if (Branch) begin
            pc_d = Target;
          end else begin
            pc_d = pc_sum[D-1:0];
            if (pc_sum[D]) begin
              ovf_d = 1'b1;
            end
          end
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StDone);
    end
  end

  assign ProgCtr  = pc_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Overflow = ovf_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

  localparam int unsigned D = 10;
  localparam int unsigned C = 16;
  localparam int unsigned PcMod  = 1 << D;
  localparam int unsigned CntMax = (1 << C) - 1;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [D-1:0] StartAddr;
  logic         Branch;
  logic [D-1:0] Target;
  logic         Stall;
  logic         Halt;
  logic [D-1:0] ProgCtr;
  logic         Busy;
  logic         Done;
  logic         Overflow;
  logic [C-1:0] CycleCnt;

  prog_counter #(.D(D), .C(C)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .StartAddr (StartAddr),
    .Branch    (Branch),
    .Target    (Target),
    .Stall     (Stall),
    .Halt      (Halt),
    .ProgCtr   (ProgCtr),
    .Busy      (Busy),
    .Done      (Done),
    .Overflow  (Overflow),
    .CycleCnt  (CycleCnt)
  );

  always #5 Clk = ~Clk;

  // Reference model: 0 = idle, 1 = running, 2 = done.
  int unsigned m_mode;
  int unsigned m_pc;
  int unsigned m_cnt;
  bit          m_ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},   ProgCtr,  m_pc);
    check({tag, ".busy"}, Busy,     (m_mode == 1) ? 1 : 0);
    check({tag, ".done"}, Done,     (m_mode == 2) ? 1 : 0);
    check({tag, ".ovf"},  Overflow, m_ovf);
    check({tag, ".cnt"},  CycleCnt, m_cnt);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    m_ovf  = 0;
  endtask

  // Apply the behavioural rules to the inputs present before the edge.
  task automatic model_edge();
    if (Start) begin
      m_mode = 1;
      m_pc   = StartAddr;
      m_cnt  = 0;
      m_ovf  = 0;
    end else if (m_mode == 1) begin
      if (m_cnt < CntMax) m_cnt++;
      if (Halt) m_mode = 2;
      else if (Stall) m_pc = m_pc;
      else if (Branch) m_pc = Target;
      else begin
        if (m_pc + 1 >= PcMod) m_ovf = 1;
        m_pc = (m_pc + 1) % PcMod;
      end
    end
  endtask

  task automatic drive(input bit st, input int unsigned sa, input bit br, input int unsigned tg,
                       input bit sl, input bit hl);
    Start     = st;
    StartAddr = sa[D-1:0];
    Branch    = br;
    Target    = tg[D-1:0];
    Stall     = sl;
    Halt      = hl;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_all("reset");
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Start at 4, then step 5, 6, 7 with CycleCnt reaching 3.
    drive(1, 4, 0, 0, 0, 0);
    step("start4");
    check("start4.lit", ProgCtr, 4);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step("inc");
    check("inc.lit_pc", ProgCtr, 7);
    check("inc.lit_cnt", CycleCnt, 3);

    // Branch chain with a self-loop.
    drive(1, 25, 0, 0, 0, 0);
    step("start25");
    drive(0, 0, 1, 26, 0, 0);
    step("br26");
    drive(0, 0, 1, 89, 0, 0);
    step("br89");
    step("loop89");
    check("loop89.lit", ProgCtr, 89);
    check("loop89.cnt", CycleCnt, 3);

    // Stall drops a concurrent branch.
    drive(1, 140, 0, 0, 0, 0);
    step("start140");
    drive(0, 0, 1, 141, 1, 0);
    step("stall1");
    step("stall2");
    check("stall.lit", ProgCtr, 140);
    drive(0, 0, 1, 141, 0, 0);
    step("br141");
    check("br141.lit", ProgCtr, 141);

    // Halt, hold in DONE, restart at 0.
    drive(1, 385, 0, 0, 0, 0);
    step("start385");
    drive(0, 0, 0, 0, 0, 1);
    step("halt");
    check("halt.done", Done, 1);
    drive(0, 0, 1, 7, 0, 0);
    repeat (5) step("donehold");
    check("donehold.cnt", CycleCnt, 1);
    drive(1, 0, 0, 0, 0, 0);
    step("restart0");

    // Wrap and sticky overflow.
    drive(1, 1022, 0, 0, 0, 0);
    step("start1022");
    drive(0, 0, 0, 0, 0, 0);
    step("pc1023");
    step("wrap");
    check("wrap.ovf", Overflow, 1);
    drive(0, 0, 1, 26, 0, 0);
    step("brkeep");
    drive(0, 0, 1, 0, 0, 0);
    step("br0");
    drive(1, 3, 0, 0, 0, 0);
    step("clrovf");
    check("clrovf.lit", Overflow, 0);

    // Async reset between edges.
    drive(1, 300, 0, 0, 0, 0);
    step("start300");
    drive(0, 0, 0, 0, 0, 0);
    #3;
    Reset = 1'b0;
    model_reset();
    #1;
    check_all("asyncrst");
    @(posedge Clk);
    #1;
    check_all("rsthold");
    Reset = 1'b1;
    repeat (2) step("idle");

    // Randomised run against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 25) == 0,
            ($urandom % 2) ? (1018 + $urandom % 6) : ($urandom % PcMod),
            ($urandom % 10) < 3, $urandom % PcMod,
            ($urandom % 5) == 0, ($urandom % 30) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Program counter stage directly upstream of the branch-target lookup table. It holds the current instruction address that drives instruction fetch. Each cycle it either advances by one, loads the absolute branch target returned by the lookup table, or holds. It also owns run control (start, halt and done) and a cycle counter used by the test harness.

Parameters:
D, 10, program counter / instruction address width
C, 16, cycle counter width

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
Start  input  1  synchronous (re)start request, level-sampled each cycle
StartAddr  input  D  program entry address loaded on Start
Branch  input  1  branch taken this cycle (same signal fed to the lookup table)
Target  input  D  absolute branch target from the lookup table (valid when Branch=1)
Stall  input  1  hold PC this cycle (e.g., multi-cycle memory op)
Halt  input  1  current instruction is halt
ProgCtr  output  D  current instruction address
Busy  output  1  1 while in RUN
Done  output  1  1 while in DONE
Overflow  output  1  sticky: PC incremented past 2^D-1 during this run
CycleCnt  output  C  cycles spent in RUN since last Start, saturating

Behaviour:
- Reset=0 (async, any time, including mid-run): state=IDLE, ProgCtr=0, Busy=0, Done=0, Overflow=0, CycleCnt=0. All outputs are registered and take these values without waiting for a clock edge.
- States: IDLE, RUN, DONE. Busy=(state==RUN) and Done=(state==DONE), both registered.
- Start=1 in any state has highest priority. At the next edge: ProgCtr=StartAddr, state=RUN, CycleCnt=0, Overflow=0.
- IDLE with Start=0: all registers hold. Branch, Stall and Halt are ignored.
- RUN priority per edge, highest first: Start > Halt > Stall > Branch > increment.
  - Halt=1: state moves to DONE and ProgCtr holds. Done rises and Busy falls one cycle after the Halt cycle.
  - Stall=1: ProgCtr holds, and a Branch on the same cycle is dropped. The instruction reissues, so the decoder reasserts Branch.
  - Branch=1: ProgCtr=Target, which takes effect in the next cycle (1-cycle latency). Target==ProgCtr is legal and holds the PC (tight loop).
  - Otherwise: ProgCtr=ProgCtr+1, modulo 2^D. Increment from 2^D-1 wraps to 0 and sets Overflow=1. Overflow stays set until Start or Reset.
  - A branch to 0 is a normal load and does not set Overflow.
- CycleCnt increments on every edge where the state is RUN and Start=0, including stall and halt cycles. It saturates at 2^C-1 (no wrap).
- DONE: ProgCtr, CycleCnt and Overflow all hold, and Done stays 1. Only Start or Reset leave DONE.
- Start in RUN is a synchronous restart. The Halt, Branch and Stall inputs in that same cycle are ignored.
- Inputs are assumed synchronous to Clk. There is no X-propagation guard on Target when Branch=0, because Target is never sampled then.

Test Plan:
- Reset=0 then release; Start=1 for 1 cycle with StartAddr=4 -> ProgCtr=4, Busy=1. Over the next 3 cycles ProgCtr steps 5, 6, 7 and CycleCnt reads 3.
- RUN at ProgCtr=25, Branch=1, Target=26 -> 26. Then Branch=1, Target=89 -> 89. Then Branch=1, Target=89 (self-loop) -> ProgCtr stays 89 with CycleCnt still incrementing.
- RUN at ProgCtr=140, Stall=1 and Branch=1 (Target=141) for 2 cycles -> ProgCtr holds 140 both cycles. Stall=0, Branch=1 -> 141.
- RUN at ProgCtr=385, Halt=1 -> next cycle Done=1, Busy=0, ProgCtr=385. Holding for 5 cycles leaves ProgCtr and CycleCnt unchanged. Start=1, StartAddr=0 -> ProgCtr=0, Busy=1, CycleCnt=0.
- Start with StartAddr=1022, run 2 cycles -> ProgCtr 1023 then 0 with Overflow=1. Then Branch to 26 -> Overflow stays 1. Start -> Overflow=0.
- Mid-run at ProgCtr=300, drop Reset=0 between clock edges -> ProgCtr=0, Busy=0, CycleCnt=0 immediately. Release Reset with no Start -> remains IDLE at 0.
